// File: rtl/pc_pkg.sv
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared types and constants for the program-counter sequencer.
//            Optional feature macro used by this slice: PC_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } pc_state_e;

  // Sequential increment handed to the external incrementer.
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // PC value loaded while reset is asserted.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Instructions are word aligned: the two low address bits are always zero.
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Combinational next-PC select. Priority: live branch target,
//            then a captured (pending) redirect, then the incrementer sum.
//            Branch targets are word aligned here.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_mux
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_br_valid,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic             i_redir_pend,
  input  logic [WIDTH-1:0] i_redir_pc,
  input  logic [WIDTH-1:0] i_inc_sum,
  output logic [WIDTH-1:0] o_br_aligned,
  output logic [WIDTH-1:0] o_next_pc
);

  // Built from the inverse of the package mask so that any WIDTH keeps all
  // upper bits set and only the two low bits cleared.
  localparam logic [WIDTH-1:0] c_align_mask = ~WIDTH'(~PC_ALIGN_MASK);

  assign o_br_aligned = i_br_target & c_align_mask;

  // Priority select of the address the PC moves to on an accept.
  always_comb begin
    o_next_pc = i_inc_sum;
    if (i_br_valid) begin
      o_next_pc = o_br_aligned;
    end else if (i_redir_pend) begin
      o_next_pc = i_redir_pc;
    end
  end

endmodule : pc_next_mux

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Front-of-pipeline program-counter sequencer. Drives the external
//            incrementer (pc + STEP), selects between the sequential address
//            and branch redirects, and issues fetches over valid/ready.
//            Optional macro PC_TRACE_EN adds a simulation-only trace printer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT),
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(PC_STEP)
) (
  input  logic             clk,
  input  logic             clear_n,
  // incrementer interface
  output logic [WIDTH-1:0] inc_a,
  output logic [WIDTH-1:0] inc_b,
  input  logic [WIDTH-1:0] inc_sum,
  // redirect and hold
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             stall,
  // instruction fetch handshake
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_addr,
  input  logic             fetch_ready,
  // status
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      cycle_count
);

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic             w_fetch_valid;
  logic             w_accept;

  logic [WIDTH-1:0] r_pc;
  logic             r_redir_pend;
  logic [WIDTH-1:0] r_redir_pc;
  logic [31:0]      r_cycle_count;

  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_br_aligned;

  // Next-PC priority select and branch target alignment.
  pc_next_mux #(
    .WIDTH (WIDTH)
  ) u_next_mux (
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .i_redir_pend (r_redir_pend),
    .i_redir_pc   (r_redir_pc),
    .i_inc_sum    (inc_sum),
    .o_br_aligned (w_br_aligned),
    .o_next_pc    (w_next_pc)
  );

  // State register; reset returns to BOOT asynchronously, which also drops
  // fetch_valid at once because valid is decoded from the state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and fetch_valid decode. stall only matters on an accept in
  // ISSUE and on every cycle in HOLD.
  always_comb begin
    w_state_next  = r_state;
    w_fetch_valid = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_fetch_valid = 1'b1;
        if (fetch_ready && stall) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_state_next = ST_ISSUE;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  assign w_accept = w_fetch_valid & fetch_ready;

  // PC and redirect bookkeeping. A strobe seen while a request is waiting
  // for ready is parked in r_redir_pc so fetch_addr stays stable until the
  // handshake completes; a newer strobe replaces an older parked one.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_pc         <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= '0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_accept) begin
            r_pc         <= w_next_pc;
            r_redir_pend <= 1'b0;
          end else if (br_valid) begin
            r_redir_pc   <= w_br_aligned;
            r_redir_pend <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (br_valid) begin
            r_pc         <= w_br_aligned;
            r_redir_pend <= 1'b0;
          end
        end
        default: begin
          // BOOT: redirects are ignored.
        end
      endcase
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cycle_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign inc_a       = r_pc;
  assign inc_b       = STEP;
  assign pc          = r_pc;
  assign fetch_addr  = r_pc;
  assign fetch_valid = w_fetch_valid;
  assign cycle_count = r_cycle_count;

`ifdef PC_TRACE_EN
  // Simulation-only trace of accepted fetches and redirect strobes.
  always @(posedge clk) begin
    if (clear_n) begin
      if (w_accept) begin
        $display("at clock %h pc %h", r_cycle_count, r_pc);
      end
      if (br_valid) begin
        $display("redirect %h", w_br_aligned);
      end
    end
  end
`else
  // Trace printer not built.
`endif

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with an external adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk;
  logic        clear_n;
  logic        br_valid;
  logic [31:0] br_target;
  logic        stall;
  logic        fetch_ready;

  // DUT with default reset PC
  logic [31:0] inc_a, inc_b, inc_sum;
  logic        fetch_valid;
  logic [31:0] fetch_addr, pc, cycle_count;

  // DUT with reset PC near the top of the address space
  logic [31:0] hi_inc_a, hi_inc_b, hi_inc_sum;
  logic        hi_fetch_valid;
  logic [31:0] hi_fetch_addr, hi_pc, hi_cycle_count;

  // External incrementers
  assign inc_sum    = inc_a + inc_b;
  assign hi_inc_sum = hi_inc_a + hi_inc_b;

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000), .STEP(32'h4)) dut (
    .clk(clk), .clear_n(clear_n),
    .inc_a(inc_a), .inc_b(inc_b), .inc_sum(inc_sum),
    .br_valid(br_valid), .br_target(br_target), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .pc(pc), .cycle_count(cycle_count)
  );

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .STEP(32'h4)) dut_hi (
    .clk(clk), .clear_n(clear_n),
    .inc_a(hi_inc_a), .inc_b(hi_inc_b), .inc_sum(hi_inc_sum),
    .br_valid(br_valid), .br_target(br_target), .stall(stall),
    .fetch_valid(hi_fetch_valid), .fetch_addr(hi_fetch_addr), .fetch_ready(fetch_ready),
    .pc(hi_pc), .cycle_count(hi_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  logic        v;
  logic [31:0] a;

  // One cycle of stimulus: apply inputs just after a falling edge, sample
  // mid-cycle, record the address of any accepted fetch, end on next fall.
  task automatic drive(input logic r, input logic b, input logic [31:0] t,
                       input logic s, output logic ov, output logic [31:0] oa);
    fetch_ready = r; br_valid = b; br_target = t; stall = s;
    #1;
    ov = fetch_valid;
    oa = fetch_addr;
    if (fetch_valid && r) got_q.push_back(fetch_addr);
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic reset_boot();
    fetch_ready = 1'b0; br_valid = 1'b0; br_target = '0; stall = 1'b0;
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", fetch_valid); else n_pass++;
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want 00000000", pc); else n_pass++;
    n_checks++; if (cycle_count !== 32'h0) $display("FAIL reset_count got %h want 0", cycle_count); else n_pass++;
    n_checks++; if (inc_b !== 32'h4) $display("FAIL inc_b got %h want 00000004", inc_b); else n_pass++;
    n_checks++; if (hi_pc !== 32'hFFFF_FFF8) $display("FAIL reset_pc_hi got %h want fffffff8", hi_pc); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_free_run();
    exp_q.delete(); got_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    clear_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    n_checks++; if (v !== 1'b0) $display("FAIL boot_valid got %b want 0", v); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
      n_checks++; if (v !== 1'b1) $display("FAIL run_valid[%0d] got %b want 1", i, v); else n_pass++;
    end
    #1;
    n_checks++; if (cycle_count !== 32'd5) $display("FAIL run_count got %0d want 5", cycle_count); else n_pass++;
    n_checks++; if (inc_a !== pc) $display("FAIL inc_a got %h want %h", inc_a, pc); else n_pass++;
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL run_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL run_addr got %h want %h", g, e); else n_pass++;
      end
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL run_extra got %0d extra want 0", got_q.size()); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ready_holdoff();
    reset_boot();
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);   exp_q.push_back(32'h8);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 1), 32'h100, 1'b0, v, a);
      n_checks++; if (v !== 1'b1 || a !== 32'h8) $display("FAIL hold_stable[%0d] got v=%b addr=%h want v=1 addr=00000008", i, v, a); else n_pass++;
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL holdoff_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL holdoff_addr got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_branch_accept();
    reset_boot();
    exp_q.push_back(32'h0);   exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    exp_q.push_back(32'h404); exp_q.push_back(32'h408);
    drive(1'b1, 1'b1, 32'h203, 1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0,   1'b0, v, a);
    drive(1'b0, 1'b1, 32'h300, 1'b0, v, a);
    n_checks++; if (a !== 32'h204) $display("FAIL br_park_addr got %h want 00000204", a); else n_pass++;
    drive(1'b1, 1'b1, 32'h407, 1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0,   1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0,   1'b0, v, a);
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL branch_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL branch_addr got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_stall_hold();
    reset_boot();
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0, 1'b1, v, a);
    drive(1'b1, 1'b0, 32'h0, 1'b1, v, a);
    n_checks++; if (v !== 1'b0 || a !== 32'h14) $display("FAIL stall_enter got v=%b pc=%h want v=0 pc=00000014", v, a); else n_pass++;
    drive(1'b1, 1'b1, 32'h40, 1'b1, v, a);
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    n_checks++; if (v !== 1'b0 || a !== 32'h40) $display("FAIL hold_branch got v=%b pc=%h want v=0 pc=00000040", v, a); else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    n_checks++; if (v !== 1'b1) $display("FAIL hold_exit got v=%b want 1", v); else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL stall_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL stall_addr got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    reset_boot();
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (hi_fetch_valid && fetch_ready) got_q.push_back(hi_fetch_addr);
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL wrap_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL wrap_addr got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    reset_boot();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    drive(1'b1, 1'b0, 32'h0,   1'b0, v, a);
    drive(1'b0, 1'b1, 32'h500, 1'b0, v, a);
    #2;
    clear_n = 1'b0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", fetch_valid); else n_pass++;
    n_checks++; if (pc !== 32'h0) $display("FAIL areset_pc got %h want 00000000", pc); else n_pass++;
    n_checks++; if (cycle_count !== 32'h0) $display("FAIL areset_count got %h want 0", cycle_count); else n_pass++;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    drive(1'b1, 1'b0, 32'h0, 1'b0, v, a);
    while (exp_q.size() > 0) begin
      logic [31:0] e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL areset_addr missing want %h", e);
      else begin
        logic [31:0] g = got_q.pop_front();
        if (g !== e) $display("FAIL areset_addr got %h want %h", g, e); else n_pass++;
      end
    end
  endtask

  initial begin
    clear_n = 1'b0; fetch_ready = 1'b0; br_valid = 1'b0;
    br_target = '0; stall = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_free_run();
    test_ready_holdoff();
    test_branch_accept();
    test_stall_hold();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_pc_sequencer

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that drives the `adder2` incrementer and consumes its sum, closing the PC + 4 loop. It holds the architectural PC, chooses between the sequential address and a branch redirect, and issues instruction-fetch requests over a valid/ready handshake. It sits at the front of the pipeline, between `adder2` and instruction memory.

## Interface
- `WIDTH`, 32: PC and address width.
- `RESET_PC`, 32'h00000000: PC value loaded on reset.
- `STEP`, 32'h00000004: increment presented to the adder.
- `clk` in 1: master clock; all state updates on the rising edge.
- `clear_n` in 1: reset; asynchronous, active-low.
- `inc_a` out WIDTH: adder operand A; always equal to `pc`.
- `inc_b` out WIDTH: adder operand B; constant `STEP`.
- `inc_sum` in WIDTH: adder result, combinational from `inc_a`/`inc_b`.
- `br_valid` in 1: single-cycle redirect strobe.
- `br_target` in WIDTH: redirect address; bits [1:0] are ignored and forced to 0.
- `stall` in 1: pipeline hold request.
- `fetch_valid` out 1: fetch request valid.
- `fetch_addr` out WIDTH: fetch address; equals `pc`.
- `fetch_ready` in 1: instruction memory accepts the request.
- `pc` out WIDTH: current PC.
- `cycle_count` out 32: free-running cycle counter.

## Operation
- States: BOOT, ISSUE, HOLD.
- Reset (`clear_n` = 0, asynchronous) sets:
  - state = BOOT, `pc` = `RESET_PC`, `fetch_valid` = 0, `cycle_count` = 0;
  - `redir_pend` = 0, `redir_pc` = 0.
- BOOT: lasts exactly one cycle after `clear_n` rises, then goes to ISSUE. `br_valid` is ignored in BOOT.
- ISSUE:
  - `fetch_valid` = 1.
  - Accept = `fetch_valid` & `fetch_ready`.
  - On accept, `pc` loads the next address. Priority is: `br_valid` target, then `redir_pc` if `redir_pend`, then `inc_sum`. `redir_pend` clears.
  - On accept with `stall` = 1, the PC still updates and the state goes to HOLD.
  - `br_valid` without accept: capture the target in `redir_pc` and set `redir_pend`. `pc` and `fetch_addr` do not change. A later strobe overwrites an earlier one.
- HOLD:
  - `fetch_valid` = 0.
  - `br_valid` loads `pc` directly with the target and clears `redir_pend`.
  - When `stall` = 0, go to ISSUE on the next cycle.
- Arithmetic: `inc_sum` is taken modulo 2^WIDTH, so 32'hFFFFFFFC wraps to 32'h00000000 with no flag. `cycle_count` increments every cycle outside reset and wraps at 2^32.

## Timing
- Sequential latency: one cycle from accept to the new `fetch_addr`. Back-to-back accepts give one fetch per cycle.
- Redirect latency:
  - strobe on the accept edge: the target appears the next cycle;
  - strobe while stalled at `fetch_ready` = 0: the target appears the cycle after the pending request is accepted.
- Handshake rule: while `fetch_valid` = 1 and `fetch_ready` = 0, `fetch_addr` must stay stable and `fetch_valid` must not drop.
- `stall` is sampled only on accept cycles in ISSUE, and on every cycle in HOLD.
- A reset asserted mid-handshake drops `fetch_valid` immediately (asynchronously) and discards any pending redirect.

## Configuration
- `PC_TRACE_EN`:
  - defined: a simulation-only block prints `at clock <cycle_count hex> pc <pc hex>` on every accept, plus `redirect <target hex>` on every `br_valid`.
  - undefined: the trace block is absent, and synthesis and RTL behaviour are unchanged.

## Structure
- Package `pc_pkg` holds:
  - the state enum (BOOT, ISSUE, HOLD);
  - `PC_STEP` = 4;
  - `PC_RESET_DEFAULT`;
  - the alignment mask 32'hFFFFFFFC.
- One sub-module, `pc_next_mux`: combinational next-PC priority select (branch, pending redirect, `inc_sum`) including target alignment. The FSM, registers and counter stay in the top.
- `adder2` is instantiated outside this block, and the bench connects it.

## Test plan
- Reset then free run with `fetch_ready` = 1: `fetch_valid` goes high the second cycle after `clear_n` rises; `fetch_addr` reads 0, 4, 8, C on successive cycles.
- `fetch_ready` = 0 for 3 cycles at PC 8, with `br_valid` and target 0x100 on the second of them: `fetch_addr` holds 8 until accept, then 0x100, then 0x104.
- `br_valid` with target 0x203 on an accept cycle: the next `fetch_addr` is 0x200; on a simultaneous pending redirect, the new strobe wins.
- `stall` = 1 on an accept at PC 0x10: `pc` becomes 0x14 and `fetch_valid` = 0. A branch to 0x40 during HOLD sets `pc` = 0x40. When `stall` drops, the next fetch is at 0x40.
- `RESET_PC` = 32'hFFFFFFF8 with `fetch_ready` = 1: addresses read FFFFFFF8, FFFFFFFC, 00000000.
- `clear_n` pulsed low asynchronously mid-handshake with a pending redirect: `fetch_valid` drops immediately, `pc` = `RESET_PC`, the pending redirect is lost and `cycle_count` = 0.
